// File: rtl/mult_pkg.sv
// Shared definitions for the signed keypad multiplier.
//   state_t        : keypad entry FSM states
//   hex7seg()      : 4-bit value to active-low {g,f,e,d,c,b,a} glyph
//   DEF_* / *_HZ   : default clock rate and timing constants
package mult_pkg;

  typedef enum logic [2:0] {
    WAIT_A_HI,
    WAIT_A_LO,
    WAIT_B_HI,
    WAIT_B_LO,
    MULT,
    DONE
  } state_t;

  localparam int DEF_CLK_FREQ_HZ     = 27_000_000;
  localparam int DEBOUNCE_RATE_HZ    = 10_000;  // 100 us settle time
  localparam int REFRESH_RATE_HZ     = 1_000;   // 1 ms per digit
  localparam int DEF_DEBOUNCE_CYCLES = DEF_CLK_FREQ_HZ / DEBOUNCE_RATE_HZ;
  localparam int DEF_REFRESH_CYCLES  = DEF_CLK_FREQ_HZ / REFRESH_RATE_HZ;

  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/mult_shift_add.sv
// Sequential 8x8 unsigned shift-add multiplier.
//   clk, reset : clock, asynchronous active-high reset
//   start      : one-cycle pulse; a/b are sampled on this edge
//   a, b       : multiplicand, multiplier
//   done       : one-cycle pulse, high 8 cycles after start
//   product    : 16-bit result, valid while done is high and after
module mult_shift_add (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        done,
  output logic [15:0] product
);

  logic [15:0] r_mcand;
  logic [7:0]  r_mplier;
  logic [15:0] r_acc;
  logic [2:0]  r_cnt;
  logic        r_busy;
  logic        r_done;

  // The start edge already folds in multiplier bit 0, so the remaining
  // seven bits finish exactly when done is raised.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_acc    <= b[0] ? {8'h00, a} : 16'h0000;
        r_mcand  <= {7'b0, a, 1'b0};
        r_mplier <= {1'b0, b[7:1]};
        r_cnt    <= 3'd1;
        r_busy   <= 1'b1;
      end else if (r_busy) begin
        r_acc    <= r_acc + (r_mplier[0] ? r_mcand : 16'h0000);
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done    = r_done;
  assign product = r_acc;

endmodule

// File: rtl/top.sv
// Signed keypad multiplier top level.
//   clk                : system clock
//   reset              : asynchronous active-high reset
//   key_in[3:0]        : keypad nibble, active-low
//   dat_ready          : asynchronous key strobe (level)
//   signo              : asynchronous operand sign, 1 = negative
//   u_display_segments : active-low {g,f,e,d,c,b,a}
//   u_display_select   : active-low one-hot digit enable, bit 0 = LSD
//   u_mult_sign        : result sign (never set for a zero magnitude)
//   u_mult_result      : unsigned result magnitude
// DEBOUNCE_CYCLES / REFRESH_CYCLES of 0 derive the value from CLK_FREQ_HZ.
module top
  import mult_pkg::*;
#(
  parameter int CLK_FREQ_HZ     = DEF_CLK_FREQ_HZ,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REFRESH_CYCLES  = DEF_REFRESH_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  key_in,
  input  logic        dat_ready,
  input  logic        signo,
  output logic [6:0]  u_display_segments,
  output logic [3:0]  u_display_select,
  output logic        u_mult_sign,
  output logic [15:0] u_mult_result
);

  localparam int DB_CYC = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES
                                                : CLK_FREQ_HZ / DEBOUNCE_RATE_HZ;
  localparam int RF_CYC = (REFRESH_CYCLES > 0) ? REFRESH_CYCLES
                                               : CLK_FREQ_HZ / REFRESH_RATE_HZ;
  localparam int DB_W = $clog2(DB_CYC + 1);
  localparam int RF_W = $clog2(RF_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);
  localparam logic [RF_W-1:0] RF_LAST = RF_W'(RF_CYC - 1);

  logic [3:0]      r_key_s1, r_key_s2;
  logic            r_rdy_s1, r_rdy_s2;
  logic            r_sgn_s1, r_sgn_s2;
  logic            r_rdy_f, r_rdy_fd;
  logic [DB_W-1:0] r_db_cnt;
  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_a, r_b;
  logic            r_sign_a, r_sign_b;
  logic            r_start;
  logic [15:0]     r_result;
  logic            r_sign;
  logic [RF_W-1:0] r_ref_cnt;
  logic [1:0]      r_digit;

  logic            w_event;
  logic            w_cap_ahi, w_cap_alo, w_cap_bhi, w_cap_blo;
  logic            w_clear, w_finish;
  logic            w_done;
  logic [15:0]     w_product;
  logic [3:0]      w_nibble;

  // Two-stage synchronisers for every asynchronous input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key_s1 <= '0;
      r_key_s2 <= '0;
      r_rdy_s1 <= 1'b0;
      r_rdy_s2 <= 1'b0;
      r_sgn_s1 <= 1'b0;
      r_sgn_s2 <= 1'b0;
    end else begin
      r_key_s1 <= key_in;
      r_key_s2 <= r_key_s1;
      r_rdy_s1 <= dat_ready;
      r_rdy_s2 <= r_rdy_s1;
      r_sgn_s1 <= signo;
      r_sgn_s2 <= r_sgn_s1;
    end
  end

  // Debounce: any sample agreeing with the filtered level restarts the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_db_cnt <= '0;
      r_rdy_f  <= 1'b0;
      r_rdy_fd <= 1'b0;
    end else begin
      r_rdy_fd <= r_rdy_f;
      if (r_rdy_s2 == r_rdy_f) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db_cnt <= '0;
        r_rdy_f  <= r_rdy_s2;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  assign w_event = r_rdy_f & ~r_rdy_fd;

  // Entry FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= WAIT_A_HI;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_cap_ahi = 1'b0;
    w_cap_alo = 1'b0;
    w_cap_bhi = 1'b0;
    w_cap_blo = 1'b0;
    w_clear   = 1'b0;
    w_finish  = 1'b0;
    case (r_state)
      WAIT_A_HI: if (w_event) begin w_cap_ahi = 1'b1; w_next = WAIT_A_LO; end
      WAIT_A_LO: if (w_event) begin w_cap_alo = 1'b1; w_next = WAIT_B_HI; end
      WAIT_B_HI: if (w_event) begin w_cap_bhi = 1'b1; w_next = WAIT_B_LO; end
      WAIT_B_LO: if (w_event) begin w_cap_blo = 1'b1; w_next = MULT;      end
      MULT:      if (w_done)  begin w_finish  = 1'b1; w_next = DONE;      end
      DONE: begin
        // A fresh key restarts entry and is itself the A high nibble
        if (w_event) begin
          w_clear   = 1'b1;
          w_cap_ahi = 1'b1;
          w_next    = WAIT_A_LO;
        end
      end
      default: w_next = WAIT_A_HI;
    endcase
  end

  // Operand capture and result latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_start  <= 1'b0;
      r_result <= '0;
      r_sign   <= 1'b0;
    end else begin
      r_start <= w_cap_blo;
      if (w_clear) begin
        r_a <= '0;
        r_b <= '0;
      end
      if (w_cap_ahi) r_a[7:4] <= ~r_key_s2;
      if (w_cap_alo) begin
        r_a[3:0] <= ~r_key_s2;
        r_sign_a <= r_sgn_s2;
      end
      if (w_cap_bhi) r_b[7:4] <= ~r_key_s2;
      if (w_cap_blo) begin
        r_b[3:0] <= ~r_key_s2;
        r_sign_b <= r_sgn_s2;
      end
      if (w_finish) begin
        r_result <= w_product;
        r_sign   <= (w_product != 16'h0000) & (r_sign_a ^ r_sign_b);
      end
    end
  end

  mult_shift_add u_mult (
    .clk     (clk),
    .reset   (reset),
    .start   (r_start),
    .a       (r_a),
    .b       (r_b),
    .done    (w_done),
    .product (w_product)
  );

  // Display scan: each digit selected for RF_CYC cycles, 0..3 then wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ref_cnt <= '0;
      r_digit   <= 2'd0;
    end else if (r_ref_cnt == RF_LAST) begin
      r_ref_cnt <= '0;
      r_digit   <= r_digit + 2'd1;
    end else begin
      r_ref_cnt <= r_ref_cnt + 1'b1;
    end
  end

  always_comb begin
    w_nibble = r_result[3:0];
    case (r_digit)
      2'd1:    w_nibble = r_result[7:4];
      2'd2:    w_nibble = r_result[11:8];
      2'd3:    w_nibble = r_result[15:12];
      default: w_nibble = r_result[3:0];
    endcase
  end

  assign u_display_select   = ~(4'b0001 << r_digit);
  assign u_display_segments = hex7seg(w_nibble);
  assign u_mult_result      = r_result;
  assign u_mult_sign        = r_sign;

endmodule

// File: tb/tb_top.sv
// Directed self-checking bench for the signed keypad multiplier.
module tb_top;

  localparam int DB   = 8;
  localparam int RF   = 16;
  localparam int HOLD = 30;
  localparam int GAP  = 30;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G9 = 7'b0010000;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  key_in;
  logic        dat_ready;
  logic        signo;
  logic [6:0]  u_display_segments;
  logic [3:0]  u_display_select;
  logic        u_mult_sign;
  logic [15:0] u_mult_result;

  int n_cmp = 0;
  int n_err = 0;

  top #(.DEBOUNCE_CYCLES(DB), .REFRESH_CYCLES(RF)) dut (
    .clk                (clk),
    .reset              (reset),
    .key_in             (key_in),
    .dat_ready          (dat_ready),
    .signo              (signo),
    .u_display_segments (u_display_segments),
    .u_display_select   (u_display_select),
    .u_mult_sign        (u_mult_sign),
    .u_mult_result      (u_mult_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic        sa;
    logic [7:0]  b;
    logic        sb;
    logic [15:0] res;
    logic        sgn;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] d, input logic s, input int hold);
    key_in = ~d;
    signo  = s;
    @(posedge clk); #1;
    dat_ready = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    dat_ready = 1'b0;
    repeat (GAP) @(posedge clk);
    #1;
  endtask

  task automatic enter(input logic [7:0] a, input logic sa,
                       input logic [7:0] b, input logic sb);
    press(a[7:4], sa, HOLD);
    press(a[3:0], sa, HOLD);
    press(b[7:4], sb, HOLD);
    press(b[3:0], sb, HOLD);
  endtask

  initial begin
    logic [15:0] old;
    int          lat;
    int          guard;

    vecs[0] = '{a:8'h05, sa:1'b1, b:8'h03, sb:1'b1, res:16'd15,   sgn:1'b0};
    vecs[1] = '{a:8'h05, sa:1'b1, b:8'h03, sb:1'b0, res:16'd15,   sgn:1'b1};
    vecs[2] = '{a:8'h00, sa:1'b1, b:8'h07, sb:1'b0, res:16'd0,    sgn:1'b0};
    vecs[3] = '{a:8'hFF, sa:1'b0, b:8'hFF, sb:1'b0, res:16'hFE01, sgn:1'b0};
    vecs[4] = '{a:8'h80, sa:1'b1, b:8'hFF, sb:1'b0, res:16'h7F80, sgn:1'b1};
    vecs[5] = '{a:8'h0F, sa:1'b0, b:8'h10, sb:1'b1, res:16'h00F0, sgn:1'b1};

    reset = 1'b1; key_in = 4'hF; dat_ready = 1'b0; signo = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", u_mult_result, 0);
    chk("rst_sign", u_mult_sign, 0);
    chk("rst_select", u_display_select, 4'b1110);
    chk("rst_segments", u_display_segments, G0);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Basic product with latency measured from the last strobe rise
    press(4'h1, 1'b0, HOLD);
    press(4'h2, 1'b0, HOLD);
    press(4'h4, 1'b0, HOLD);
    key_in = ~4'h1;
    @(posedge clk); #1;
    old = u_mult_result;
    dat_ready = 1'b1;
    lat = 0;
    while (u_mult_result == old && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 3 + DB + 9);
    repeat (HOLD) @(posedge clk);
    #1;
    dat_ready = 1'b0;
    repeat (GAP) @(posedge clk);
    #1;
    chk("basic_result", u_mult_result, 16'h0492);
    chk("basic_sign", u_mult_sign, 0);

    // Display scan, aligned to the start of digit 0
    guard = 0;
    while (u_display_select == 4'b1110 && guard < 5 * RF) begin
      @(posedge clk); #1; guard++;
    end
    while (u_display_select != 4'b1110 && guard < 10 * RF) begin
      @(posedge clk); #1; guard++;
    end
    chk("scan_sel0", u_display_select, 4'b1110);
    chk("scan_seg0", u_display_segments, G2);
    repeat (RF) @(posedge clk);
    #1;
    chk("scan_sel1", u_display_select, 4'b1101);
    chk("scan_seg1", u_display_segments, G9);
    repeat (RF) @(posedge clk);
    #1;
    chk("scan_sel2", u_display_select, 4'b1011);
    chk("scan_seg2", u_display_segments, G4);
    repeat (RF) @(posedge clk);
    #1;
    chk("scan_sel3", u_display_select, 4'b0111);
    chk("scan_seg3", u_display_segments, G0);

    // A short glitch mid-entry must not capture; a long hold captures once
    press(4'h0, 1'b1, HOLD);
    press(4'hF, 1'b1, DB / 2);
    press(4'h5, 1'b1, 4 * HOLD);
    press(4'h0, 1'b0, HOLD);
    press(4'h3, 1'b0, HOLD);
    chk("bounce_result", u_mult_result, 16'd15);
    chk("bounce_sign", u_mult_sign, 1);

    for (int i = 0; i < 6; i++) begin
      enter(vecs[i].a, vecs[i].sa, vecs[i].b, vecs[i].sb);
      chk($sformatf("vec%0d_result", i), u_mult_result, vecs[i].res);
      chk($sformatf("vec%0d_sign", i), u_mult_sign, vecs[i].sgn);
    end

    // Reset 3 cycles after the multiplier start
    press(4'h3, 1'b0, HOLD);
    press(4'h3, 1'b0, HOLD);
    press(4'h3, 1'b0, HOLD);
    key_in = ~4'h3;
    @(posedge clk); #1;
    dat_ready = 1'b1;
    repeat (2 + DB + 1 + 3) @(posedge clk);
    #2;
    reset = 1'b1;
    dat_ready = 1'b0;
    #1;
    chk("midrst_result", u_mult_result, 0);
    chk("midrst_sign", u_mult_sign, 0);
    chk("midrst_select", u_display_select, 4'b1110);
    chk("midrst_segments", u_display_segments, G0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (GAP) @(posedge clk);
    #1;
    chk("postrst_idle", u_mult_result, 0);
    enter(8'h12, 1'b0, 8'h41, 1'b1);
    chk("postrst_result", u_mult_result, 16'h0492);
    chk("postrst_sign", u_mult_sign, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/top.md
Name: top

Overview:
- Top level of the signed keypad multiplier.
- Synchronises and debounces the data-ready strobe, then captures four keypad nibbles: two per 8-bit operand.
- Multiplies the operand magnitudes with a sequential shift-add unit and computes the sign separately (sign-magnitude).
- Shows the 16-bit magnitude as four hex digits on a multiplexed 7-segment display.

Parameters:
- CLK_FREQ_HZ, 27_000_000, system clock frequency.
- DEBOUNCE_CYCLES, 2700, cycles `dat_ready` must stay stable before an edge is accepted (100 us).
- REFRESH_CYCLES, 27_000, cycles each display digit stays selected (1 ms per digit).

Ports:
- clk  in  1  system clock, 27 MHz.
- reset  in  1  asynchronous, active-high reset.
- key_in  in  4  keypad nibble, active-low; digit value = ~key_in.
- dat_ready  in  1  key-valid strobe, level, asynchronous to clk.
- signo  in  1  operand sign (1 = negative), asynchronous to clk.
- u_display_segments  out  7  segments {g,f,e,d,c,b,a}, active-low.
- u_display_select  out  4  digit enables, active-low one-hot; bit 0 = least-significant digit.
- u_mult_sign  out  1  result sign.
- u_mult_result  out  16  unsigned result magnitude.

Behaviour:
- Input synchronisation:
  - key_in, dat_ready and signo each pass through a 2-FF synchroniser.
  - dat_ready is then debounced: the filtered level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - Only the rising edge of the filtered dat_ready counts as a key event.
- Entry FSM states: WAIT_A_HI, WAIT_A_LO, WAIT_B_HI, WAIT_B_LO, MULT, DONE.
- Key event in each wait state:
  - WAIT_A_HI: a_reg[7:4] = ~key_in.
  - WAIT_A_LO: a_reg[3:0] = ~key_in; sign_a = signo.
  - WAIT_B_HI: b_reg[7:4] = ~key_in.
  - WAIT_B_LO: b_reg[3:0] = ~key_in; sign_b = signo; start the multiplier.
- MULT state:
  - Shift-add multiply: one multiplier bit per cycle, 8 cycles, 16-bit accumulator.
  - Key events arriving during MULT are ignored.
- Transition to DONE, in the same edge:
  - u_mult_result = a_reg*b_reg.
  - u_mult_sign = sign_a ^ sign_b.
  - Latency from the WAIT_B_LO capture edge to the outputs updating is 9 cycles.
- Result sign rules:
  - If the magnitude is 0, u_mult_sign is forced to 0 (no negative zero).
  - No overflow is possible, since the maximum is 255*255 = 65025.
- DONE state:
  - Outputs hold their values.
  - The next key event clears a_reg and b_reg, goes to WAIT_A_HI and is consumed as the A high nibble.
  - u_mult_result and u_mult_sign keep their old values until the next completion.
- Display:
  - A free-running counter advances the selected digit every REFRESH_CYCLES, in order 0,1,2,3 and wrapping back to 0.
  - Digit n shows hex value u_mult_result[4n+3:4n] (0–F glyphs).
  - Exactly one select bit is low at any time.
- Reset (asynchronous, active-high; also when asserted mid-entry or mid-multiply):
  - State = WAIT_A_HI; operands, signs, accumulator, debounce and refresh counters = 0.
  - u_mult_result = 0, u_mult_sign = 0.
  - u_display_select = 4'b1110; u_display_segments = glyph "0" = 7'b1000000.
- Bounce: a dat_ready pulse shorter than DEBOUNCE_CYCLES produces no event. Holding dat_ready high produces exactly one event.

Decomposition:
- Package mult_pkg: entry-state enum; hex-to-7-segment function/constant table; default constants for DEBOUNCE_CYCLES and REFRESH_CYCLES.
- One sub-module, mult_shift_add:
  - Ports clk, reset, start, a[7:0], b[7:0], done, product[15:0].
  - done pulses for one cycle, 8 cycles after start.
- Synchroniser, debouncer and display multiplexer stay inline in top.

Test Plan:
- Reset: assert reset -> u_mult_result=0, u_mult_sign=0, select=1110, segments=1000000.
- Basic product: keys 1110,1101,1011,1110 (digits 1,2,4,1), signo=0, dat_ready held 200 us per key -> result 0x12*0x41 = 0x0492 (1170), sign 0, 9 cycles after the fourth capture.
- Signs: A=0x05 with signo=1, B=0x03 with signo=0 -> result 15, sign 1.
- Signs: same operands with both signs 1 -> result 15, sign 0.
- Zero and maximum:
  - A=0x00 with signo=1 -> result 0, sign 0.
  - A=0xFF, B=0xFF -> result 65025 (0xFE01).
- Bounce: dat_ready pulse of 50 us -> no capture; FSM state unchanged.
- Display scan: with result 0x0492, step through 4 refresh periods -> select 1110/1101/1011/0111 with glyphs 2, 9, 4, 0 respectively.
- Reset mid-multiply: assert reset 3 cycles after start -> outputs 0, state WAIT_A_HI.
